// File: rtl/pool2_cu_pkg.sv
// pool2_cu_pkg: shared FSM state encoding and handshake width for the pool2 control unit
package pool2_cu_pkg;
  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
  localparam int HS_W = 1;
endpackage

// File: rtl/pool2_cu_delay_n_1.sv
// delay_n_1: N-cycle single-bit delay line, cleared by asynchronous active-high reset
// ports: clk, reset, d (input bit), q (d delayed N cycles)
module delay_n_1 #(
  parameter int N = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic [N-1:0] sr;
  always_ff @(posedge clk or posedge reset)
    if (reset) sr <= '0;
    else begin
      sr[0] <= d;
      for (int i = 1; i < N; i++) sr[i] <= sr[i-1];
    end
  assign q = sr[N-1];
endmodule

// File: rtl/pool2_cu.sv
// pool2_cu: second pooling stage control unit, walks pooling windows over the conv2 map
// ports: clk/reset; start_from_previous/end_to_previous upstream handshake; ifm read enable/address;
//        pool_load/pool_enable to the max/avg datapath; next-stage write enable/address;
//        end_from_next/start_to_next downstream handshake
module pool2_cu
  import pool2_cu_pkg::*;
#(
  parameter int IFM_SIZE              = 10,
  parameter int POOL_SIZE             = 2,
  parameter int READ_LATENCY          = 1,
  parameter int IFM_SIZE_NEXT         = IFM_SIZE / POOL_SIZE,
  parameter int ADDRESS_SIZE_IFM      = $clog2(IFM_SIZE * IFM_SIZE),
  parameter int ADDRESS_SIZE_NEXT_IFM = $clog2(IFM_SIZE_NEXT * IFM_SIZE_NEXT)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [HS_W-1:0]                  start_from_previous,
  output logic [HS_W-1:0]                  end_to_previous,
  output logic                             ifm_enable_read_current,
  output logic [ADDRESS_SIZE_IFM-1:0]      ifm_address_read_current,
  output logic                             pool_load,
  output logic                             pool_enable,
  output logic                             ifm_enable_write_next,
  output logic [ADDRESS_SIZE_NEXT_IFM-1:0] ifm_address_write_next,
  input  logic [HS_W-1:0]                  end_from_next,
  output logic [HS_W-1:0]                  start_to_next
);
  localparam int WW = POOL_SIZE > 1 ? $clog2(POOL_SIZE) : 1;
  localparam int OW = IFM_SIZE_NEXT > 1 ? $clog2(IFM_SIZE_NEXT) : 1;
  localparam int DW = $clog2(READ_LATENCY + 2);
  state_t state;
  logic [WW-1:0] win_col, win_row, n_win_col, n_win_row;
  logic [OW-1:0] out_col, out_row, n_out_col, n_out_row;
  logic [DW-1:0] drain_cnt;
  logic start_pending, out_full, go, last_rd, rd_first, rd_last, wr_last;
  logic wc_max, wr_max, oc_max, or_max;
  function automatic logic [ADDRESS_SIZE_IFM-1:0] rd_addr(input logic [OW-1:0] orow, ocol,
                                                           input logic [WW-1:0] wrow, wcol);
    return ADDRESS_SIZE_IFM'((int'(orow) * POOL_SIZE + int'(wrow)) * IFM_SIZE
                             + int'(ocol) * POOL_SIZE + int'(wcol));
  endfunction
  always_comb begin
    wc_max    = win_col == WW'(POOL_SIZE - 1);
    wr_max    = win_row == WW'(POOL_SIZE - 1);
    oc_max    = out_col == OW'(IFM_SIZE_NEXT - 1);
    or_max    = out_row == OW'(IFM_SIZE_NEXT - 1);
    n_win_col = wc_max ? '0 : win_col + 1'b1;
    n_win_row = wc_max ? (wr_max ? '0 : win_row + 1'b1) : win_row;
    n_out_col = (wc_max & wr_max) ? (oc_max ? '0 : out_col + 1'b1) : out_col;
    n_out_row = (wc_max & wr_max & oc_max) ? (or_max ? '0 : out_row + 1'b1) : out_row;
    last_rd   = wc_max & wr_max & oc_max & or_max;
  end
  assign go              = (start_from_previous | start_pending) & ~out_full;
  assign end_to_previous = (state == IDLE) & ~start_pending;
  // counters always describe the read currently on the bus, so the window flags come straight from them
  assign rd_first        = ifm_enable_read_current & (win_row == '0) & (win_col == '0);
  assign rd_last         = ifm_enable_read_current & wc_max & wr_max;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state                    <= IDLE;
      win_col                  <= '0;
      win_row                  <= '0;
      out_col                  <= '0;
      out_row                  <= '0;
      drain_cnt                <= '0;
      start_pending            <= 1'b0;
      ifm_enable_read_current  <= 1'b0;
      ifm_address_read_current <= '0;
    end else
      case (state)
        IDLE: begin
          start_pending <= ~go & (start_pending | start_from_previous);
          if (go) begin
            state                    <= READ;
            ifm_enable_read_current  <= 1'b1;
            ifm_address_read_current <= '0;
          end
        end
        READ: begin
          win_col                  <= n_win_col;
          win_row                  <= n_win_row;
          out_col                  <= n_out_col;
          out_row                  <= n_out_row;
          ifm_address_read_current <= rd_addr(n_out_row, n_out_col, n_win_row, n_win_col);
          if (last_rd) begin
            state                   <= DRAIN;
            ifm_enable_read_current <= 1'b0;
          end
        end
        DRAIN: begin
          drain_cnt <= drain_cnt + 1'b1;
          if (drain_cnt == DW'(READ_LATENCY)) begin
            state     <= IDLE;
            drain_cnt <= '0;
          end
        end
        default: state <= IDLE;
      endcase
  delay_n_1 #(.N(READ_LATENCY)) u_pool_enable (
    .clk(clk), .reset(reset), .d(ifm_enable_read_current), .q(pool_enable)
  );
  delay_n_1 #(.N(READ_LATENCY)) u_pool_load (
    .clk(clk), .reset(reset), .d(rd_first), .q(pool_load)
  );
  // one extra stage: the datapath result is ready the cycle after the window's last sample
  delay_n_1 #(.N(READ_LATENCY + 1)) u_write (
    .clk(clk), .reset(reset), .d(rd_last), .q(ifm_enable_write_next)
  );
  assign wr_last       = ifm_address_write_next == ADDRESS_SIZE_NEXT_IFM'(IFM_SIZE_NEXT * IFM_SIZE_NEXT - 1);
  assign start_to_next = out_full & end_from_next;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ifm_address_write_next <= '0;
      out_full               <= 1'b0;
    end else begin
      if (ifm_enable_write_next) ifm_address_write_next <= wr_last ? '0 : ifm_address_write_next + 1'b1;
      out_full <= (ifm_enable_write_next & wr_last) | (out_full & ~end_from_next);
    end
endmodule

// File: tb/tb_pool2_cu.sv
// tb_pool2_cu: directed self-checking bench for pool2_cu (10x10 map, 2x2 windows, read latency 1)
module tb_pool2_cu;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_from_previous = 1'b0;
  logic       end_from_next = 1'b1;
  logic       end_to_previous, ifm_enable_read_current, pool_load, pool_enable;
  logic       ifm_enable_write_next, start_to_next;
  logic [6:0] ifm_address_read_current;
  logic [4:0] ifm_address_write_next;
  int         checks = 0;
  int         failures = 0;
  int         rd_log[100];
  pool2_cu dut (
    .clk(clk), .reset(reset), .start_from_previous(start_from_previous), .end_to_previous(end_to_previous),
    .ifm_enable_read_current(ifm_enable_read_current), .ifm_address_read_current(ifm_address_read_current),
    .pool_load(pool_load), .pool_enable(pool_enable), .ifm_enable_write_next(ifm_enable_write_next),
    .ifm_address_write_next(ifm_address_write_next), .end_from_next(end_from_next), .start_to_next(start_to_next)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic pulse_start();
    start_from_previous = 1'b1;
    tick();
    start_from_previous = 1'b0;
  endtask
  function automatic int exp_addr(input int i);
    return ((i / 20) * 2 + (i / 2) % 2) * 10 + ((i / 4) % 5) * 2 + i % 2;
  endfunction
  task automatic idle_checks(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      checks++;
      if ({end_to_previous, ifm_enable_read_current, ifm_enable_write_next, start_to_next, pool_enable} !== 5'b10000) begin
        failures++;
        $display("FAIL %s cycle %0d etp/rd/wr/stn/pe got=%b exp=10000", tag, k,
                 {end_to_previous, ifm_enable_read_current, ifm_enable_write_next, start_to_next, pool_enable});
      end
      tick();
    end
  endtask
  // follows one full pass from its first read; efn is the level end_from_next holds throughout
  task automatic observe_pass(input string tag, input bit efn);
    int  ri = 0, wc = 0, lr = 1000, lw = -100, pulses = 0, pe_cnt = 0, w = 0;
    bit  en_d1 = 0, first_d1 = 0, last_d1 = 0, last_d2 = 0, cf, cl;
    while (!ifm_enable_read_current && w < 4) begin
      tick();
      w++;
    end
    checks++;
    if (ifm_enable_read_current !== 1'b1) begin
      failures++;
      $display("FAIL %s_first_read got=%b exp=1", tag, ifm_enable_read_current);
    end
    for (int c = 0; c < 130; c++) begin
      cf = 0;
      cl = 0;
      checks++;
      if ({pool_enable, pool_load, ifm_enable_write_next} !== {en_d1, first_d1, last_d2}) begin
        failures++;
        $display("FAIL %s_pipe c=%0d pe/pl/we got=%b exp=%b", tag, c,
                 {pool_enable, pool_load, ifm_enable_write_next}, {en_d1, first_d1, last_d2});
      end
      if (pool_enable) pe_cnt++;
      if (ifm_enable_read_current) begin
        checks++;
        if (ri < 100 && int'(ifm_address_read_current) !== exp_addr(ri)) begin
          failures++;
          $display("FAIL %s_rd_addr idx=%0d got=%0d exp=%0d", tag, ri, ifm_address_read_current, exp_addr(ri));
        end
        if (ri < 100) rd_log[ri] = int'(ifm_address_read_current);
        cf = (ri % 4) == 0;
        cl = (ri % 4) == 3;
        if (ri == 99) lr = c;
        ri++;
      end
      checks++;
      if (end_to_previous !== (c >= lr + 3)) begin
        failures++;
        $display("FAIL %s_end_to_previous c=%0d got=%b exp=%b", tag, c, end_to_previous, c >= lr + 3);
      end
      if (ifm_enable_write_next) begin
        checks++;
        if (int'(ifm_address_write_next) !== wc) begin
          failures++;
          $display("FAIL %s_wr_addr n=%0d got=%0d exp=%0d", tag, wc, ifm_address_write_next, wc);
        end
        wc++;
        if (wc == 25) lw = c;
      end
      checks++;
      if (start_to_next !== (efn && c == lw + 1)) begin
        failures++;
        $display("FAIL %s_start_to_next c=%0d got=%b exp=%b", tag, c, start_to_next, efn && c == lw + 1);
      end
      if (start_to_next) pulses++;
      last_d2  = last_d1;
      last_d1  = ifm_enable_read_current && cl;
      first_d1 = ifm_enable_read_current && cf;
      en_d1    = ifm_enable_read_current;
      tick();
    end
    checks++;
    if (ri !== 100 || wc !== 25 || pe_cnt !== 100 || pulses !== int'(efn)) begin
      failures++;
      $display("FAIL %s_totals reads=%0d writes=%0d pool_en=%0d stn=%0d exp 100/25/100/%0d",
               tag, ri, wc, pe_cnt, pulses, efn);
    end
  endtask
  task automatic test_reset();
    reset = 1'b1;
    tick();
    checks++;
    if ({ifm_address_read_current, ifm_address_write_next, pool_load} !== 13'd0) begin
      failures++;
      $display("FAIL reset_addr got=%0d/%0d/%b exp=0/0/0", ifm_address_read_current, ifm_address_write_next, pool_load);
    end
    idle_checks("reset_held", 2);
    reset = 1'b0;
    idle_checks("reset_idle", 10);
  endtask
  task automatic test_full_pass();
    end_from_next = 1'b1;
    pulse_start();
    observe_pass("full", 1'b1);
    checks++;
    if (rd_log[2] !== 10 || rd_log[3] !== 11 || rd_log[4] !== 2 || rd_log[98] !== 98 || rd_log[99] !== 99) begin
      failures++;
      $display("FAIL full_seq got=%0d,%0d,%0d,%0d,%0d exp=10,11,2,98,99",
               rd_log[2], rd_log[3], rd_log[4], rd_log[98], rd_log[99]);
    end
    idle_checks("full_after", 3);
  endtask
  task automatic test_backpressure();
    end_from_next = 1'b0;
    pulse_start();
    observe_pass("held", 1'b0);
    idle_checks("held_full", 5);
    pulse_start();
    for (int k = 0; k < 5; k++) begin
      checks++;
      if ({end_to_previous, ifm_enable_read_current, start_to_next} !== 3'b000) begin
        failures++;
        $display("FAIL pending c=%0d etp/rd/stn got=%b exp=000", k,
                 {end_to_previous, ifm_enable_read_current, start_to_next});
      end
      tick();
    end
    end_from_next = 1'b1;
    #1;
    checks++;
    if (start_to_next !== 1'b1 || ifm_enable_read_current !== 1'b0) begin
      failures++;
      $display("FAIL release stn/rd got=%b%b exp=10", start_to_next, ifm_enable_read_current);
    end
    tick();
    checks++;
    if (start_to_next !== 1'b0) begin
      failures++;
      $display("FAIL release_once stn got=%b exp=0", start_to_next);
    end
    observe_pass("second", 1'b1);
  endtask
  task automatic test_reset_mid();
    pulse_start();
    repeat (57) tick();
    checks++;
    if (ifm_enable_read_current !== 1'b1 || ifm_address_read_current !== 7'd49) begin
      failures++;
      $display("FAIL mid_read57 rd/addr got=%b/%0d exp=1/49", ifm_enable_read_current, ifm_address_read_current);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({end_to_previous, ifm_enable_read_current, ifm_address_read_current, pool_load, pool_enable,
         ifm_enable_write_next, ifm_address_write_next, start_to_next} !== {1'b1, 17'd0}) begin
      failures++;
      $display("FAIL mid_reset outputs got=%b rd_addr=%0d wr_addr=%0d exp all zero except etp",
               {end_to_previous, ifm_enable_read_current, pool_load, pool_enable, ifm_enable_write_next, start_to_next},
               ifm_address_read_current, ifm_address_write_next);
    end
    tick();
    reset = 1'b0;
    idle_checks("mid_after", 10);
    pulse_start();
    observe_pass("restart", 1'b1);
  endtask
  initial begin
    test_reset();
    test_full_pass();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
